// File: rtl/mpu_pkg.sv
// mpu_pkg: shared opcodes, BRAM selects, NOP encoding and sequencer states
package mpu_pkg;
  localparam logic [3:0] OP_LOAD   = 4'b0100;
  localparam logic [3:0] OP_COPY   = 4'b0101;
  localparam logic [3:0] OP_UNLOAD = 4'b0110;
  localparam logic [3:0] OP_CLEAR  = 4'b0111;
  localparam logic [3:0] OP_ADD    = 4'b1100;
  localparam logic [3:0] OP_SHIFT  = 4'b1101;
  localparam logic [3:0] OP_SUB    = 4'b1110;
  localparam logic [3:0] OP_MULT   = 4'b1111;
  localparam logic [1:0] SEL_B0 = 2'd0;
  localparam logic [1:0] SEL_B1 = 2'd1;
  localparam logic [1:0] SEL_B2 = 2'd2;
  localparam logic [1:0] SEL_B3 = 2'd3;
  localparam logic [7:0] INSTR_NOP = 8'h00;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_DRAIN} seq_state_e;
  // LOAD and UNLOAD are the only opcodes that stream a full buffer row
  function automatic logic is_xfer(input logic [3:0] op);
    return op == OP_LOAD || op == OP_UNLOAD;
  endfunction
endpackage

// File: rtl/seq_stage_buf.sv
// seq_stage_buf: 64x8 staging buffer, one sync write port, host and stream async read ports
module seq_stage_buf (
  input  logic       clk,
  input  logic       we_i,
  input  logic [5:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [5:0] host_raddr_i,
  output logic [7:0] host_rdata_o,
  input  logic [5:0] stream_raddr_i,
  output logic [7:0] stream_rdata_o
);
  logic [7:0] mem_q [64];
  // contents deliberately survive reset
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign host_rdata_o   = mem_q[host_raddr_i];
  assign stream_rdata_o = mem_q[stream_raddr_i];
endmodule

// File: rtl/host_cmd_sequencer.sv
// host_cmd_sequencer: issues host commands to the controller and streams the staging buffer; HOST_SEQ_WATCHDOG_EN adds a drain watchdog
module host_cmd_sequencer
  import mpu_pkg::*;
#(
  parameter int NUM_BYTES   = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_dd,
  input  logic [1:0] cmd_aa,
  output logic [7:0] host_instruction,
  input  logic       fsm_busy,
  input  logic       buf_wr_en,
  input  logic [5:0] buf_wr_addr,
  input  logic [7:0] buf_wr_data,
  input  logic [5:0] buf_rd_addr,
  output logic [7:0] buf_rd_data,
  output logic [7:0] load_byte,
  input  logic [7:0] unload_byte,
  output logic       done,
  output logic       err
);
  if (NUM_BYTES != 64 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("host_cmd_sequencer: NUM_BYTES must be 64 and TIMEOUT_CYC at least 1");
  end
  seq_state_e state_q;
  logic [3:0] op_q;
  logic [7:0] instr_q;
  logic [5:0] idx_q;
  logic       done_q;
  logic       load_run, unload_run, last_run, buf_we;
  logic [7:0] stream_byte;
`ifdef HOST_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign load_run         = state_q == S_RUN && op_q == OP_LOAD;
  assign unload_run       = state_q == S_RUN && op_q == OP_UNLOAD;
  assign last_run         = !is_xfer(op_q) || idx_q == 6'(NUM_BYTES - 1);
  assign cmd_ready        = state_q == S_IDLE && !fsm_busy && !reset;
  assign host_instruction = instr_q;
  assign load_byte        = load_run ? stream_byte : 8'h00;
  assign done             = done_q;
  assign buf_we           = unload_run || (buf_wr_en && !load_run);
  seq_stage_buf u_buf (
    .clk            (clk),
    .we_i           (buf_we),
    .waddr_i        (unload_run ? idx_q : buf_wr_addr),
    .wdata_i        (unload_run ? unload_byte : buf_wr_data),
    .host_raddr_i   (buf_rd_addr),
    .host_rdata_o   (buf_rd_data),
    .stream_raddr_i (idx_q),
    .stream_rdata_o (stream_byte)
  );
  // command sequencing: latch, issue, run (stream/capture), drain until the controller is idle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 4'h0;
      instr_q <= INSTR_NOP;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef HOST_SEQ_WATCHDOG_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE:
          if (cmd_valid && cmd_ready) begin
            op_q    <= cmd_op;
            instr_q <= cmd_op[3:2] == 2'b00 ? INSTR_NOP : {cmd_dd, cmd_aa, cmd_op};
            state_q <= S_ISSUE;
          end
        S_ISSUE: begin
          idx_q   <= '0;
          state_q <= op_q[3:2] == 2'b00 ? S_DRAIN : S_RUN;
        end
        S_RUN:
          if (last_run) begin
            idx_q   <= '0;
            instr_q <= INSTR_NOP;
            state_q <= S_DRAIN;
          end else idx_q <= idx_q + 6'd1;
        S_DRAIN:
`ifdef HOST_SEQ_WATCHDOG_EN
          if (!fsm_busy || wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
            err_q   <= err_q | fsm_busy;
            wd_q    <= '0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else wd_q <= wd_q + 1'b1;
`else
          if (!fsm_busy) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
endmodule
